// File: rtl/dll_replay_if.sv
// Bundle between the replay controller and its three neighbours: the
// TL-side retry buffer writer (store), the DLLP receive path (ack/nak)
// and the PIPE-side transmit mux (replay reads, freed space).
//   store_*        : new TLP record offered by the retry buffer writer
//   table_full_o   : record table holds its maximum number of TLPs
//   ack_*          : received ACK/NAK DLLP
//   free_*         : one purged record and the buffer address it frees up to
//   rd_*           : replay read requests to the retry buffer
//   replay_*       : replay status, REPLAY_NUM counter
//   retrain_o      : REPLAY_NUM rollover pulse
//   dllp_err_o     : ACK/NAK named a sequence number never transmitted
interface dll_replay_if #(
  parameter int unsigned PTR_BITS = 10
);
  logic                store_valid_i;
  logic [11:0]         store_seq_i;
  logic [PTR_BITS-1:0] store_ptr_i;
  logic [2:0]          store_size_i;
  logic                table_full_o;
  logic                ack_valid_i;
  logic                ack_nak_i;
  logic [11:0]         ack_seq_i;
  logic                free_valid_o;
  logic [PTR_BITS-1:0] free_ptr_o;
  logic                rd_en_o;
  logic [PTR_BITS-1:0] rd_addr_o;
  logic                rd_ready_i;
  logic                replay_active_o;
  logic [1:0]          replay_num_o;
  logic                retrain_o;
  logic                dllp_err_o;

  modport master (
    output store_valid_i, store_seq_i, store_ptr_i, store_size_i,
    output ack_valid_i, ack_nak_i, ack_seq_i, rd_ready_i,
    input  table_full_o, free_valid_o, free_ptr_o, rd_en_o, rd_addr_o,
    input  replay_active_o, replay_num_o, retrain_o, dllp_err_o
  );

  modport slave (
    input  store_valid_i, store_seq_i, store_ptr_i, store_size_i,
    input  ack_valid_i, ack_nak_i, ack_seq_i, rd_ready_i,
    output table_full_o, free_valid_o, free_ptr_o, rd_en_o, rd_addr_o,
    output replay_active_o, replay_num_o, retrain_o, dllp_err_o
  );
endinterface

// File: rtl/dll_replay_ctrl.sv
// Data Link Layer replay controller. Keeps a FIFO of {seq, ptr, size}
// records for every TLP held in the retry buffer, purges acknowledged
// records (returning the freed buffer address), and on NAK or replay
// timeout walks the outstanding records issuing beat-by-beat reads.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dll_replay_if.slave (store, ack/nak, free, replay read,
//                status and error pulses)
module dll_replay_ctrl #(
  parameter int unsigned RETRY_DEPTH_LG2    = 10,
  parameter int unsigned TABLE_DEPTH_LG2    = 5,
  parameter int unsigned REPLAY_TIMER_LIMIT = 711
) (
  input  logic         clk,
  input  logic         rst_n,
  dll_replay_if.slave  bus
);
  localparam int unsigned PTR_BITS  = RETRY_DEPTH_LG2;
  localparam int unsigned IDX_BITS  = TABLE_DEPTH_LG2;
  localparam int unsigned CNT_BITS  = TABLE_DEPTH_LG2 + 1;
  localparam int unsigned TAB_DEPTH = 1 << TABLE_DEPTH_LG2;
  localparam int unsigned SEQ_BITS  = 12;
  localparam int unsigned TMR_BITS  =
    (REPLAY_TIMER_LIMIT > 2) ? $clog2(REPLAY_TIMER_LIMIT) : 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_REPLAY = 1'b1} state_e;

  // a <= b in modulo-4096 sequence space
  function automatic logic seq_le(input logic [SEQ_BITS-1:0] a,
                                  input logic [SEQ_BITS-1:0] b);
    logic [SEQ_BITS-1:0] d;
    d = b - a;
    return !d[SEQ_BITS-1];
  endfunction

  state_e              state_q, state_d;
  logic [SEQ_BITS-1:0] rec_seq_q  [TAB_DEPTH];
  logic [PTR_BITS-1:0] rec_ptr_q  [TAB_DEPTH];
  logic [2:0]          rec_size_q [TAB_DEPTH];
  logic [IDX_BITS-1:0] head_q, head_d, tail_q, tail_d, rp_idx_q, rp_idx_d;
  logic [CNT_BITS-1:0] count_q, count_d, replay_len_q, replay_len_d;
  logic [2:0]          beat_q, beat_d;
  logic [TMR_BITS-1:0] timer_q, timer_d;
  logic [SEQ_BITS-1:0] tail_seq_q, tail_seq_d, ack_pend_q, ack_pend_d;
  logic                nak_pend_q, nak_pend_d;
  logic [1:0]          replay_num_q, replay_num_d;
  logic                retrain_q, retrain_d, dllp_err_q, dllp_err_d;

  logic                table_full, store_acc, pop, last_pop, settled;
  logic                expire, trigger, ack_beyond, ack_ok;
  logic [IDX_BITS-1:0] head_nxt;
  logic [SEQ_BITS-1:0] head_seq, ref_seq;
  logic [CNT_BITS-1:0] remain;
  logic [1:0]          rnum_base;

  // Next-state: record FIFO, ack tracking, purge, replay sequencing
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    rp_idx_d     = rp_idx_q;
    replay_len_d = replay_len_q;
    beat_d       = beat_q;
    timer_d      = timer_q;
    tail_seq_d   = tail_seq_q;
    ack_pend_d   = ack_pend_q;
    nak_pend_d   = nak_pend_q;
    retrain_d    = 1'b0;

    table_full = (count_q == CNT_BITS'(TAB_DEPTH));
    store_acc  = bus.store_valid_i && !table_full;
    head_seq   = rec_seq_q[head_q];
    head_nxt   = head_q + IDX_BITS'(1);

    // Purge only in IDLE; the last pop of a burst may also start a replay
    pop      = (state_q == ST_IDLE) && (count_q != '0) && seq_le(head_seq, ack_pend_q);
    last_pop = pop && ((count_q == CNT_BITS'(1)) ||
                       !seq_le(rec_seq_q[head_nxt], ack_pend_q));
    remain   = count_q - CNT_BITS'(pop);
    settled  = (state_q == ST_IDLE) && (!pop || last_pop);
    expire   = (timer_q == TMR_BITS'(REPLAY_TIMER_LIMIT - 1));
    trigger  = settled && (remain != '0) && (nak_pend_q || (expire && !pop));

    // With an empty table the newest transmitted seq stands in for head-1
    ref_seq    = (count_q != '0) ? head_seq - SEQ_BITS'(1) : tail_seq_q;
    ack_beyond = !seq_le(bus.ack_seq_i, tail_seq_q);
    ack_ok     = bus.ack_valid_i && !ack_beyond && seq_le(ref_seq, bus.ack_seq_i);
    dllp_err_d = bus.ack_valid_i && ack_beyond;

    if (store_acc) begin
      tail_d     = tail_q + IDX_BITS'(1);
      tail_seq_d = bus.store_seq_i;
    end
    if (pop) head_d = head_nxt;
    count_d = count_q + CNT_BITS'(store_acc) - CNT_BITS'(pop);

    rnum_base    = pop ? 2'd0 : replay_num_q;
    replay_num_d = rnum_base;

    case (state_q)
      ST_IDLE: begin
        if (pop || (count_q == '0)) timer_d = '0;
        else                        timer_d = timer_q + TMR_BITS'(1);
        if (settled && ((remain == '0) || trigger)) nak_pend_d = 1'b0;
        if (trigger) begin
          state_d      = ST_REPLAY;
          timer_d      = '0;
          replay_len_d = remain;
          rp_idx_d     = head_d;
          beat_d       = '0;
          if (rnum_base == 2'd3) begin
            replay_num_d = 2'd0;
            retrain_d    = 1'b1;
          end else begin
            replay_num_d = rnum_base + 2'd1;
          end
        end
      end
      ST_REPLAY: begin
        timer_d = '0;
        if (bus.rd_ready_i) begin
          if (beat_q == rec_size_q[rp_idx_q]) begin
            beat_d       = '0;
            rp_idx_d     = rp_idx_q + IDX_BITS'(1);
            replay_len_d = replay_len_q - CNT_BITS'(1);
            if (replay_len_q == CNT_BITS'(1)) state_d = ST_IDLE;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Cumulative ack: never move the acknowledged point backwards
    if (ack_ok) begin
      if (seq_le(ack_pend_q, bus.ack_seq_i)) ack_pend_d = bus.ack_seq_i;
      if (bus.ack_nak_i) nak_pend_d = 1'b1;
    end
    // First record into an empty table re-anchors the ack point just below it
    if (store_acc && (count_q == '0)) ack_pend_d = bus.store_seq_i - SEQ_BITS'(1);
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      head_q       <= '0;
      tail_q       <= '0;
      rp_idx_q     <= '0;
      count_q      <= '0;
      replay_len_q <= '0;
      beat_q       <= '0;
      timer_q      <= '0;
      tail_seq_q   <= '1;
      ack_pend_q   <= '1;
      nak_pend_q   <= 1'b0;
      replay_num_q <= 2'd0;
      retrain_q    <= 1'b0;
      dllp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      rp_idx_q     <= rp_idx_d;
      count_q      <= count_d;
      replay_len_q <= replay_len_d;
      beat_q       <= beat_d;
      timer_q      <= timer_d;
      tail_seq_q   <= tail_seq_d;
      ack_pend_q   <= ack_pend_d;
      nak_pend_q   <= nak_pend_d;
      replay_num_q <= replay_num_d;
      retrain_q    <= retrain_d;
      dllp_err_q   <= dllp_err_d;
    end
  end

  // Record storage; entries are only read while counted as valid
  always_ff @(posedge clk) begin
    if (store_acc) begin
      rec_seq_q[tail_q]  <= bus.store_seq_i;
      rec_ptr_q[tail_q]  <= bus.store_ptr_i;
      rec_size_q[tail_q] <= bus.store_size_i;
    end
  end

  assign bus.table_full_o    = table_full;
  assign bus.free_valid_o    = pop;
  assign bus.free_ptr_o      = pop ? PTR_BITS'(rec_ptr_q[head_q] +
                                   PTR_BITS'(rec_size_q[head_q]) + PTR_BITS'(1)) : '0;
  assign bus.rd_en_o         = (state_q == ST_REPLAY);
  assign bus.rd_addr_o       = (state_q == ST_REPLAY) ?
                               PTR_BITS'(rec_ptr_q[rp_idx_q] + PTR_BITS'(beat_q)) : '0;
  assign bus.replay_active_o = (state_q == ST_REPLAY);
  assign bus.replay_num_o    = replay_num_q;
  assign bus.retrain_o       = retrain_q;
  assign bus.dllp_err_o      = dllp_err_q;
endmodule

// File: tb/tb_dll_replay_ctrl.sv
// Bench for dll_replay_ctrl: directed scenarios plus a randomized phase,
// all checked against a queue-based model of the outstanding TLP list.
module tb_dll_replay_ctrl;
  localparam int unsigned PB = 10;

  typedef struct { int seq; int ptr; int size; } rec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dll_replay_if #(.PTR_BITS(PB)) bus ();

  dll_replay_ctrl #(
    .RETRY_DEPTH_LG2(10), .TABLE_DEPTH_LG2(5), .REPLAY_TIMER_LIMIT(711)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  rec_t mq[$];
  int   m_tail;
  int   m_rnum;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit le(input int a, input int b);
    return ((b - a) & 4095) < 2048;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.store_valid_i = 1'b0; bus.store_seq_i = '0; bus.store_ptr_i = '0;
    bus.store_size_i = '0; bus.ack_valid_i = 1'b0; bus.ack_nak_i = 1'b0;
    bus.ack_seq_i = '0; bus.rd_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    mq.delete(); m_tail = 4095; m_rnum = 0;
  endtask

  task automatic do_store(input int seq, input int ptr, input int size);
    bus.store_valid_i = 1'b1; bus.store_seq_i = 12'(seq);
    bus.store_ptr_i = PB'(ptr); bus.store_size_i = 3'(size);
    cyc();
    bus.store_valid_i = 1'b0;
    if (mq.size() < 32) begin
      mq.push_back('{seq, ptr, size});
      m_tail = seq;
    end
    chk("table_full", bus.table_full_o, mq.size() == 32);
  endtask

  // Walk a replay: expected read stream is every beat of every outstanding record
  task automatic run_replay(input int mode);
    int addrs[$];
    int idx, guard;
    bit rdy;
    foreach (mq[i]) for (int b = 0; b <= mq[i].size; b++) addrs.push_back((mq[i].ptr + b) % 1024);
    chk("replay_active", bus.replay_active_o, 1);
    chk("replay_num", bus.replay_num_o, m_rnum);
    idx = 0; guard = 0;
    while (idx < addrs.size() && guard < 2000) begin
      chk("rd_en", bus.rd_en_o, 1);
      chk("rd_addr", bus.rd_addr_o, addrs[idx]);
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? guard[0] : 1'($urandom_range(0, 1));
      bus.rd_ready_i = rdy;
      cyc();
      if (rdy) idx++;
      guard++;
    end
    bus.rd_ready_i = 1'b0;
    if (idx < addrs.size()) chk("replay_timeout", idx, addrs.size());
    chk("replay_done", bus.replay_active_o, 0);
    chk("rd_en_off", bus.rd_en_o, 0);
  endtask

  task automatic do_ack(input bit nak, input int seq, input int mode);
    int  head_ref, npop;
    bit  beyond, dup;
    bus.ack_valid_i = 1'b1; bus.ack_nak_i = nak; bus.ack_seq_i = 12'(seq);
    cyc();
    bus.ack_valid_i = 1'b0; bus.ack_nak_i = 1'b0;
    beyond   = !le(seq, m_tail);
    head_ref = (mq.size() > 0) ? mq[0].seq : ((m_tail + 1) & 4095);
    dup      = !beyond && !le((head_ref + 4095) & 4095, seq);
    chk("dllp_err", bus.dllp_err_o, beyond);
    npop = 0;
    if (!beyond && !dup) while (npop < mq.size() && le(mq[npop].seq, seq)) npop++;
    for (int i = 0; i < npop; i++) begin
      chk("free_valid", bus.free_valid_o, 1);
      chk("free_ptr", bus.free_ptr_o, (mq[0].ptr + mq[0].size + 1) % 1024);
      void'(mq.pop_front());
      m_rnum = 0;
      cyc();
    end
    chk("free_idle", bus.free_valid_o, 0);
    if (nak && !beyond && !dup && mq.size() > 0) begin
      if (npop == 0) begin
        chk("pre_replay", bus.replay_active_o, 0);
        cyc();
      end
      m_rnum = (m_rnum == 3) ? 0 : m_rnum + 1;
      run_replay(mode);
    end else begin
      chk("no_replay", bus.replay_active_o, 0);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base, s, r, k, n, cur;

    // Reset state
    rst_n = 1'b0;
    idle_inputs();
    cyc(); cyc();
    chk("rst_full", bus.table_full_o, 0);
    chk("rst_free", bus.free_valid_o, 0);
    chk("rst_free_ptr", bus.free_ptr_o, 0);
    chk("rst_rd_en", bus.rd_en_o, 0);
    chk("rst_rd_addr", bus.rd_addr_o, 0);
    chk("rst_active", bus.replay_active_o, 0);
    chk("rst_rnum", bus.replay_num_o, 0);
    chk("rst_retrain", bus.retrain_o, 0);
    chk("rst_dllp_err", bus.dllp_err_o, 0);

    // Cumulative ACK purge
    do_reset();
    for (int i = 0; i < 4; i++) do_store(i, 2 * i, 1);
    do_ack(1'b0, 1, 0);
    chk("ack_rnum", bus.replay_num_o, 0);
    do_ack(1'b0, 3, 0);

    // NAK with address wrap and throttled transmit path
    do_reset();
    do_store(10, 1020, 0);
    do_store(11, 1022, 3);
    do_ack(1'b1, 10, 1);

    // Replay timer expiry, four times in a row -> retrain
    do_reset();
    do_store($urandom_range(0, 4095), $urandom_range(0, 1023), $urandom_range(0, 7));
    for (int t = 1; t <= 4; t++) begin
      repeat (710) cyc();
      chk("tmr_not_yet", bus.replay_active_o, 0);
      cyc();
      m_rnum = (m_rnum == 3) ? 0 : m_rnum + 1;
      chk("retrain", bus.retrain_o, t == 4);
      run_replay(0);
    end

    // Sequence number wrap and an ACK beyond the newest TLP
    do_reset();
    do_store(4094, $urandom_range(0, 1023), $urandom_range(0, 7));
    do_store(4095, $urandom_range(0, 1023), $urandom_range(0, 7));
    do_store(0, $urandom_range(0, 1023), $urandom_range(0, 7));
    do_ack(1'b0, 0, 0);
    do_ack(1'b0, 5, 0);
    cyc();
    chk("dllp_err_pulse", bus.dllp_err_o, 0);

    // Full table, dropped 33rd store, NAK coinciding with timer expiry
    do_reset();
    base = $urandom_range(0, 4095);
    for (int i = 0; i < 33; i++)
      do_store((base + i) & 4095, $urandom_range(0, 1023), $urandom_range(0, 7));
    repeat (677) cyc();
    do_ack(1'b1, (base + 4095) & 4095, 2);
    repeat (5) cyc();
    chk("single_replay", bus.replay_active_o, 0);
    chk("single_rnum", bus.replay_num_o, 1);
    do_ack(1'b0, (base + 32) & 4095, 0);
    do_ack(1'b0, (base + 31) & 4095, 0);

    // Reset in the middle of a replay
    do_reset();
    do_store(100, $urandom_range(0, 1023), 7);
    bus.ack_valid_i = 1'b1; bus.ack_nak_i = 1'b1; bus.ack_seq_i = 12'd99;
    cyc();
    bus.ack_valid_i = 1'b0; bus.ack_nak_i = 1'b0;
    cyc();
    chk("mid_active", bus.replay_active_o, 1);
    bus.rd_ready_i = 1'b1;
    cyc(); cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_en", bus.rd_en_o, 0);
    chk("mid_rst_active", bus.replay_active_o, 0);
    cyc();
    rst_n = 1'b1;
    bus.rd_ready_i = 1'b0;
    cyc();
    mq.delete(); m_tail = 4095; m_rnum = 0;
    do_ack(1'b1, 4095, 0);
    repeat (3) cyc();
    chk("mid_post_idle", bus.replay_active_o, 0);
    chk("mid_post_full", bus.table_full_o, 0);
    do_store(0, $urandom_range(0, 1023), $urandom_range(0, 7));
    do_ack(1'b0, 0, 0);

    // Randomized traffic against the model
    do_reset();
    cur = $urandom_range(0, 4095);
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 6);
      for (int j = 0; j < n; j++) begin
        if (mq.size() < 32) begin
          do_store(cur, $urandom_range(0, 1023), $urandom_range(0, 7));
          cur = (cur + 1) & 4095;
        end
      end
      r = $urandom_range(0, 9);
      if (r == 0) begin
        do_ack(1'($urandom_range(0, 1)), (m_tail + $urandom_range(1, 100)) & 4095, 2);
      end else if (r == 1 && mq.size() > 0) begin
        s = (mq[0].seq + 4095 - $urandom_range(1, 200)) & 4095;
        do_ack(1'($urandom_range(0, 1)), s, 2);
      end else if (mq.size() > 0) begin
        k = $urandom_range(0, mq.size() - 1);
        do_ack(1'($urandom_range(0, 1)), mq[k].seq, 2);
      end
    end
    do_ack(1'b0, m_tail, 0);
    chk("final_rnum", bus.replay_num_o, m_rnum);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
